// File: rtl/mips32_boot_loader_if.sv
// Byte-stream receive, memory word-write and core-control signals of the mips32 program loader.
// The master modport is the loader side; the slave modport is the host/core side.
interface mips32_boot_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_halt;
    logic              cpu_pc_load;
    logic [31:0]       cpu_pc;
    logic              done;
    logic              err;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata,
        output cpu_halt, cpu_pc_load, cpu_pc, done, err
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_halt, cpu_pc_load, cpu_pc, done, err
    );
endinterface

// File: rtl/mips32_boot_loader.sv
// Framed byte-stream loader: writes big-endian words into core memory, holds the core halted
// while loading, then loads the entry PC and releases the core once the checksum matches.
module mips32_boot_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter logic [7:0]  MAGIC  = 8'hA5
) (
    input  logic                  clk1,
    input  logic                  rst,
    mips32_boot_loader_if.master  bus
);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BUF_W  = 24;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_ADDR    = 4'd1;
    localparam logic [3:0] S_CNT     = 4'd2;
    localparam logic [3:0] S_PC      = 4'd3;
    localparam logic [3:0] S_PAYLOAD = 4'd4;
    localparam logic [3:0] S_CSUM    = 4'd5;
    localparam logic [3:0] S_RELEASE = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_ERROR   = 4'd8;

    logic [3:0]        state_q,   state_nxt;
    logic [1:0]        byte_q,    byte_nxt;
    logic [ADDR_W-1:0] start_q,   start_nxt;
    logic [CNT_W-1:0]  cnt_q,     cnt_nxt;
    logic [CNT_W-1:0]  index_q,   index_nxt;
    logic [WORD_W-1:0] entry_q,   entry_nxt;
    logic [BUF_W-1:0]  buf_q,     buf_nxt;
    logic [7:0]        csum_q,    csum_nxt;
    logic              we_q,      we_nxt;
    logic [ADDR_W-1:0] addr_q,    addr_nxt;
    logic [WORD_W-1:0] wdata_q,   wdata_nxt;
    logic              halt_q,    halt_nxt;
    logic              pcl_q,     pcl_nxt;
    logic [WORD_W-1:0] pc_q,      pc_nxt;
    logic              done_q,    done_nxt;
    logic              err_q,     err_nxt;
    logic              ready_c;
    logic              fire_c;

    // Stall the sender only during the single release cycle.
    assign ready_c = !rst && (state_q != S_RELEASE);
    assign fire_c  = bus.rx_valid && ready_c;

    assign bus.rx_ready    = ready_c;
    assign bus.mem_we      = we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.cpu_halt    = halt_q;
    assign bus.cpu_pc_load = pcl_q;
    assign bus.cpu_pc      = pc_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            byte_q  <= '0;
            start_q <= '0;
            cnt_q   <= '0;
            index_q <= '0;
            entry_q <= '0;
            buf_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            halt_q  <= 1'b1;
            pcl_q   <= 1'b0;
            pc_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            byte_q  <= byte_nxt;
            start_q <= start_nxt;
            cnt_q   <= cnt_nxt;
            index_q <= index_nxt;
            entry_q <= entry_nxt;
            buf_q   <= buf_nxt;
            csum_q  <= csum_nxt;
            we_q    <= we_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            halt_q  <= halt_nxt;
            pcl_q   <= pcl_nxt;
            pc_q    <= pc_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        byte_nxt  = byte_q;
        start_nxt = start_q;
        cnt_nxt   = cnt_q;
        index_nxt = index_q;
        entry_nxt = entry_q;
        buf_nxt   = buf_q;
        csum_nxt  = csum_q;
        we_nxt    = 1'b0;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        halt_nxt  = halt_q;
        pcl_nxt   = 1'b0;
        pc_nxt    = pc_q;
        done_nxt  = done_q;
        err_nxt   = err_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                // Anything other than MAGIC is swallowed while waiting for a frame.
                if (fire_c && (bus.rx_data == MAGIC)) begin
                    state_nxt = S_ADDR;
                    byte_nxt  = 2'd0;
                    csum_nxt  = 8'd0;
                    index_nxt = '0;
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                    halt_nxt  = 1'b1;
                end
            end
            S_ADDR: begin
                if (fire_c) begin
                    // Shifting through an ADDR_W-wide register drops the unused high bits.
                    start_nxt = ADDR_W'({start_q, bus.rx_data});
                    csum_nxt  = csum_q ^ bus.rx_data;
                    byte_nxt  = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        state_nxt = S_CNT;
                    end
                end
            end
            S_CNT: begin
                if (fire_c) begin
                    cnt_nxt  = {cnt_q[7:0], bus.rx_data};
                    csum_nxt = csum_q ^ bus.rx_data;
                    byte_nxt = byte_q + 2'd1;
                    if (byte_q == 2'd1) begin
                        state_nxt = S_PC;
                        byte_nxt  = 2'd0;
                    end
                end
            end
            S_PC: begin
                if (fire_c) begin
                    entry_nxt = {entry_q[23:0], bus.rx_data};
                    csum_nxt  = csum_q ^ bus.rx_data;
                    byte_nxt  = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        state_nxt = (cnt_q != '0) ? S_PAYLOAD : S_CSUM;
                    end
                end
            end
            S_PAYLOAD: begin
                if (fire_c) begin
                    buf_nxt  = {buf_q[15:0], bus.rx_data};
                    csum_nxt = csum_q ^ bus.rx_data;
                    byte_nxt = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        we_nxt    = 1'b1;
                        addr_nxt  = start_q + ADDR_W'(index_q);
                        wdata_nxt = {buf_q, bus.rx_data};
                        index_nxt = index_q + CNT_W'(1);
                        if (index_q == (cnt_q - CNT_W'(1))) begin
                            state_nxt = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (fire_c) begin
                    if (bus.rx_data == csum_q) begin
                        state_nxt = S_RELEASE;
                        pcl_nxt   = 1'b1;
                        pc_nxt    = entry_q;
                    end else begin
                        state_nxt = S_ERROR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            S_RELEASE: begin
                state_nxt = S_DONE;
                halt_nxt  = 1'b0;
                done_nxt  = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mips32_boot_loader.sv
// Directed bench for mips32_boot_loader: builds framed images, watches memory writes and
// the release handshake, and compares against hand-derived expectations.
module tb_mips32_boot_loader;
    logic clk1;
    logic rst;

    mips32_boot_loader_if #(.ADDR_W(10)) bus ();

    mips32_boot_loader #(.ADDR_W(10), .MAGIC(8'hA5)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus.master)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_fail   = 0;
    bit gaps     = 1'b0;

    logic [31:0] img[$];
    logic [7:0]  fr[$];
    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          pc_loads = 0;
    logic [31:0] last_pc  = '0;

    logic [31:0] prog [11] = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000,
                                32'h0e94a000, 32'h14431000, 32'h2c630001, 32'h0e94a000,
                                32'h3460fffc, 32'h2542fffe, 32'hfc000000};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write and PC-load monitor, sampled mid-cycle.
    always @(negedge clk1) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
        end
        if (bus.cpu_pc_load === 1'b1) begin
            pc_loads++;
            last_pc = bus.cpu_pc;
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        pc_loads = 0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        if (gaps) begin
            bus.rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk1);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && guard < 50) begin
            @(negedge clk1);
            guard++;
        end
        if (guard >= 50) check("rx_ready_timeout", 64'(bus.rx_ready), 64'd1);
        @(negedge clk1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic build_frame(input logic [31:0] start, input logic [15:0] n,
                               input logic [31:0] pc, input logic [7:0] csum_flip);
        logic [7:0] cs = 8'd0;
        fr.delete();
        fr.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) fr.push_back(start[i*8 +: 8]);
        fr.push_back(n[15:8]);
        fr.push_back(n[7:0]);
        for (int i = 3; i >= 0; i--) fr.push_back(pc[i*8 +: 8]);
        for (int w = 0; w < int'(n); w++)
            for (int i = 3; i >= 0; i--) fr.push_back(img[w][i*8 +: 8]);
        for (int i = 1; i < fr.size(); i++) cs ^= fr[i];
        fr.push_back(cs ^ csum_flip);
    endtask

    // Sends the first 'count' bytes of fr, checking halt after MAGIC and write latency.
    task automatic send_frame(input int count);
        for (int k = 0; k < count; k++) begin
            send_byte(fr[k]);
            if (k == 0) check("halt_after_magic", 64'(bus.cpu_halt), 64'd1);
            if (k >= 11 && k < fr.size() - 1 && ((k - 11) % 4) == 3)
                check("we_latency", 64'(bus.mem_we), 64'd1);
        end
    endtask

    task automatic expect_release(input logic [31:0] pc);
        check("rel_pc_load", 64'(bus.cpu_pc_load), 64'd1);
        check("rel_pc", 64'(bus.cpu_pc), 64'(pc));
        check("rel_ready_low", 64'(bus.rx_ready), 64'd0);
        check("rel_still_halted", 64'(bus.cpu_halt), 64'd1);
        @(negedge clk1);
        check("rel_halt_low", 64'(bus.cpu_halt), 64'd0);
        check("rel_done", 64'(bus.done), 64'd1);
        check("rel_err", 64'(bus.err), 64'd0);
        check("rel_pulse_once", 64'(pc_loads), 64'd1);
        check("rel_last_pc", 64'(last_pc), 64'(pc));
    endtask

    task automatic expect_writes(input logic [9:0] start, input int n);
        check("wr_count", 64'(wr_addr.size()), 64'(n));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check($sformatf("wr_addr_%0d", i), 64'(wr_addr[i]), 64'(10'(start + 10'(i))));
            check($sformatf("wr_data_%0d", i), 64'(wr_data[i]), 64'(img[i]));
        end
    endtask

    task automatic load_prog();
        img.delete();
        foreach (prog[i]) img.push_back(prog[i]);
    endtask

    initial begin
        rst          = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        // Reset behaviour
        repeat (3) @(negedge clk1);
        check("rst_ready_low", 64'(bus.rx_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk1);
        check("rst_halt", 64'(bus.cpu_halt), 64'd1);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_ready", 64'(bus.rx_ready), 64'd1);
        check("rst_pc", 64'(bus.cpu_pc), 64'd0);
        check("rst_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
        send_byte(8'h3C);
        repeat (4) @(negedge clk1);
        check("rst_no_writes", 64'(wr_addr.size()), 64'd0);
        check("junk_ignored_halt", 64'(bus.cpu_halt), 64'd1);

        // Good frame, back-to-back bytes, then again with idle gaps
        for (int pass = 0; pass < 2; pass++) begin
            gaps = (pass == 1);
            load_prog();
            clear_log();
            build_frame(32'd0, 16'd11, 32'd0, 8'h00);
            send_frame(fr.size());
            expect_release(32'd0);
            expect_writes(10'd0, 11);
        end
        gaps = 1'b0;

        // Bad checksum: error, core stays halted, no release
        clear_log();
        build_frame(32'd0, 16'd11, 32'd0, 8'h01);
        send_frame(fr.size());
        check("bad_err", 64'(bus.err), 64'd1);
        repeat (3) @(negedge clk1);
        check("bad_halt", 64'(bus.cpu_halt), 64'd1);
        check("bad_done", 64'(bus.done), 64'd0);
        check("bad_no_pc_load", 64'(pc_loads), 64'd0);
        check("bad_writes_kept", 64'(wr_addr.size()), 64'd11);

        // Recovery frame at address 200
        img.delete();
        img.push_back(32'h00000007);
        clear_log();
        build_frame(32'd200, 16'd1, 32'h00000100, 8'h00);
        send_frame(fr.size());
        expect_release(32'h00000100);
        expect_writes(10'd200, 1);

        // Zero-length image
        clear_log();
        build_frame(32'd0, 16'd0, 32'h00000014, 8'h00);
        send_frame(fr.size());
        expect_release(32'h00000014);
        check("zero_no_writes", 64'(wr_addr.size()), 64'd0);

        // Address wrap with ignored upper start bits and MAGIC bytes in the payload
        img.delete();
        img.push_back(32'hA5A5A5A5);
        img.push_back(32'h12A5_3456);
        clear_log();
        build_frame(32'h8000_03FF, 16'd2, 32'h00000040, 8'h00);
        send_frame(fr.size());
        expect_release(32'h00000040);
        expect_writes(10'd1023, 2);

        // Reset after two bytes of the third word
        load_prog();
        clear_log();
        build_frame(32'd0, 16'd11, 32'd0, 8'h00);
        send_frame(11 + 4*2 + 2);
        rst = 1'b1;
        @(negedge clk1);
        check("mid_rst_halt", 64'(bus.cpu_halt), 64'd1);
        check("mid_rst_done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk1);
        check("mid_rst_writes", 64'(wr_addr.size()), 64'd2);
        check("mid_rst_halt_hold", 64'(bus.cpu_halt), 64'd1);

        // Fresh frame after the reset
        clear_log();
        build_frame(32'd5, 16'd3, 32'h00000008, 8'h00);
        send_frame(fr.size());
        expect_release(32'h00000008);
        expect_writes(10'd5, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Overall guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end
endmodule
